io_switch_led: RTL

Memory-mapped LED/switch peripheral that consumes the chip selects, I/O strobes and write data produced by the memory/IO address-decode stage. It also returns the 16-bit `io_rdata` that stage muxes into the register-file write-back path. It holds a 24-bit LED output register, and synchronises and debounces the 24 board switches. A sticky "switch changed" flag lets software poll for input events. Writes take effect at the clock edge; reads are combinational within the single-cycle datapath.

---
 rtl/io_switch_led.sv | 118 +++++++++++
 1 files changed

// File: rtl/io_switch_led.sv
// Memory-mapped LED output register and synchronised/debounced switch input port.
// Define SW_DEBOUNCE_EN to enable the debounce counter; otherwise switches are only synchronised.
module io_switch_led #(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int CNT_W           = 18
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        LEDCtrl,
    input  logic        SwitchCtrl,
    input  logic        ioRead,
    input  logic        ioWrite,
    input  logic [1:0]  io_addr,
    input  logic [15:0] io_wdata,
    output logic [15:0] io_rdata,
    input  logic [23:0] sw,
    output logic [23:0] led
);

    localparam logic [1:0] OFS_LO = 2'b00;
    localparam logic [1:0] OFS_HI = 2'b10;

    // Reject parameter sets the debounce counter cannot represent.
    if (DEBOUNCE_CYCLES < 2 || CNT_W < 2 || (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_param_check
        $error("io_switch_led: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
    end

    logic [23:0] s1;
    logic [23:0] s2;
    logic [23:0] sw_db;
    logic [23:0] sw_db_next;
    logic        sw_evt;
    logic        sw_rd_hi;

    assign sw_rd_hi = SwitchCtrl && ioRead && (io_addr == OFS_HI);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led <= '0;
        end else if (LEDCtrl && ioWrite) begin
            case (io_addr)
                OFS_LO:  led[15:0]  <= io_wdata;
                OFS_HI:  led[23:16] <= io_wdata[7:0];
                default: ;
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous board switches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

`ifdef SW_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [23:0]      cand;
    logic [CNT_W-1:0] cnt;

    // Any difference from the candidate restarts the stability window.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cand <= '0;
            cnt  <= '0;
        end else if (s2 != cand) begin
            cand <= s2;
            cnt  <= '0;
        end else if (cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sw_db_next = ((s2 == cand) && (cnt == CNT_LAST)) ? cand : sw_db;
`else
    assign sw_db_next = s2;
`endif

    // A new debounced value sets the flag even if software is reading it on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_db  <= '0;
            sw_evt <= 1'b0;
        end else begin
            sw_db <= sw_db_next;
            if (sw_db_next != sw_db) begin
                sw_evt <= 1'b1;
            end else if (sw_rd_hi) begin
                sw_evt <= 1'b0;
            end
        end
    end

    // NOTE: io_rdata gets a default first so no path through the mux infers a latch.
    always_comb begin
        io_rdata = '0;
        if (SwitchCtrl && ioRead) begin
            case (io_addr)
                OFS_LO:  io_rdata = sw_db[15:0];
                OFS_HI:  io_rdata = {sw_evt, 7'b0, sw_db[23:16]};
                default: io_rdata = '0;
            endcase
        end else if (LEDCtrl && ioRead) begin
            case (io_addr)
                OFS_LO:  io_rdata = led[15:0];
                OFS_HI:  io_rdata = {8'h00, led[23:16]};
                default: io_rdata = '0;
            endcase
        end
    end

endmodule
